operand_serializer: RTL and testbench

Upstream feeder for the serial adder datapath. Accepts a pair of parallel WIDTH-bit operands over a valid/ready handshake. Shifts them out one bit per clock on two serial lines, which drive the adder's serial_in_a/serial_in_b, with framing strobes that mark the first and last bit of each operand. Supports back-to-back frames and an optional idle gap between frames.

---
 rtl/operand_serializer.sv | 144 ++++++++++++++
 tb/tb_operand_serializer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/operand_serializer.sv
// Purpose: converts a parallel operand pair into two framed serial bit streams.
// Latency: accept on edge k puts bit 0 of the frame on the lines in cycle k+1; a frame lasts WIDTH cycles.
// Backpressure: in_ready is low mid-frame and during the gap; the source holds in_valid and its data until accepted.
module operand_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             serial_out_a,
    output logic             serial_out_b,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam bit HAS_GAP = (GAP > 0);
    // Only meaningful when HAS_GAP; the GAP state is unreachable otherwise.
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_a_nxt;
    logic [WIDTH-1:0] sh_b, sh_b_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [3:0]       gap_cnt, gap_cnt_nxt;

    logic last_bit;
    logic accept;
    logic head_a;
    logic head_b;

    // Move every register one position toward the output end; vacated bits fill with 0.
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v);
        if (LSB_FIRST) begin
            return {1'b0, v[WIDTH-1:1]};
        end else begin
            return {v[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Status and handshake decode from registered state only.
    always_comb begin
        last_bit  = (state == S_SHIFT) && (bit_cnt == LAST_BIT);
        // Without a gap the last bit cycle can take the next pair, giving seamless frames.
        in_ready  = (state == S_IDLE) || (last_bit && !HAS_GAP);
        accept    = in_valid && in_ready;
        bit_valid = (state == S_SHIFT);
        busy      = (state != S_IDLE);
    end

    // Serial lines come straight from the register end bit, forced to 0 outside valid cycles.
    always_comb begin
        head_a       = LSB_FIRST ? sh_a[0] : sh_a[WIDTH-1];
        head_b       = LSB_FIRST ? sh_b[0] : sh_b[WIDTH-1];
        serial_out_a = bit_valid && head_a;
        serial_out_b = bit_valid && head_b;
        frame_start  = bit_valid && (bit_cnt == '0);
        frame_last   = last_bit;
    end

    // Next-state, shift and counter logic.
    always_comb begin
        state_nxt   = state;
        sh_a_nxt    = sh_a;
        sh_b_nxt    = sh_b;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    sh_a_nxt    = in_a;
                    sh_b_nxt    = in_b;
                    bit_cnt_nxt = '0;
                    state_nxt   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                sh_a_nxt    = shift1(sh_a);
                sh_b_nxt    = shift1(sh_b);
                bit_cnt_nxt = bit_cnt + 1'b1;
                if (last_bit) begin
                    bit_cnt_nxt = '0;
                    if (HAS_GAP) begin
                        gap_cnt_nxt = '0;
                        state_nxt   = S_GAP;
                    end else if (accept) begin
                        // Back-to-back: the new pair replaces the drained registers.
                        sh_a_nxt  = in_a;
                        sh_b_nxt  = in_b;
                        state_nxt = S_SHIFT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end

            S_GAP: begin
                gap_cnt_nxt = gap_cnt + 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset drops any frame in flight and wins over a simultaneous accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            sh_a    <= '0;
            sh_b    <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            sh_a    <= sh_a_nxt;
            sh_b    <= sh_b_nxt;
            bit_cnt <= bit_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_operand_serializer.sv
// Purpose: directed checks of operand_serializer in LSB-first, MSB-first and gapped configurations.
// Latency: outputs sampled on the falling edge, one cycle per expected bit position.
// Backpressure: in_valid held across busy periods to confirm nothing is taken while in_ready is low.
module tb_operand_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] vld;
    logic [3:0] a0, b0, a1, b1, a2, b2;
    logic [2:0] rdy, sa, sb, bv, fs, fl, bsy;

    int checks = 0;
    int failures = 0;

    operand_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_a(a0), .in_b(b0), .serial_out_a(sa[0]), .serial_out_b(sb[0]),
        .bit_valid(bv[0]), .frame_start(fs[0]), .frame_last(fl[0]), .busy(bsy[0])
    );

    operand_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .GAP(0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_a(a1), .in_b(b1), .serial_out_a(sa[1]), .serial_out_b(sb[1]),
        .bit_valid(bv[1]), .frame_start(fs[1]), .frame_last(fl[1]), .busy(bsy[1])
    );

    operand_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .GAP(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in_a(a2), .in_b(b2), .serial_out_a(sa[2]), .serial_out_b(sb[2]),
        .bit_valid(bv[2]), .frame_start(fs[2]), .frame_last(fl[2]), .busy(bsy[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Checks n consecutive cycles of instance d; bit i of each mask is the expected value in cycle i.
    task automatic watch(input string tag, input int d, input int n,
                         input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ebv,
                         input logic [15:0] efs, input logic [15:0] efl, input logic [15:0] erdy,
                         input logic [15:0] ebsy);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_c%0d_bv", tag, i),   32'(bv[d]),  32'(ebv[i]));
            chk($sformatf("%s_c%0d_sa", tag, i),   32'(sa[d]),  32'(ea[i]));
            chk($sformatf("%s_c%0d_sb", tag, i),   32'(sb[d]),  32'(eb[i]));
            chk($sformatf("%s_c%0d_fs", tag, i),   32'(fs[d]),  32'(efs[i]));
            chk($sformatf("%s_c%0d_fl", tag, i),   32'(fl[d]),  32'(efl[i]));
            chk($sformatf("%s_c%0d_rdy", tag, i),  32'(rdy[d]), 32'(erdy[i]));
            chk($sformatf("%s_c%0d_busy", tag, i), 32'(bsy[d]), 32'(ebsy[i]));
        end
    endtask

    // All three instances idle: only in_ready may be high.
    task automatic idle_check(input string tag);
        chk({tag, "_rdy"},  32'(rdy), 32'h7);
        chk({tag, "_bv"},   32'(bv),  32'h0);
        chk({tag, "_busy"}, 32'(bsy), 32'h0);
        chk({tag, "_sa"},   32'(sa),  32'h0);
        chk({tag, "_sb"},   32'(sb),  32'h0);
        chk({tag, "_fs"},   32'(fs),  32'h0);
        chk({tag, "_fl"},   32'(fl),  32'h0);
    endtask

    initial begin
        vld = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_check("reset");
        reset = 1'b0;

        // Basic frame: a=1011 b=0110, LSB first; input change after accept must not matter.
        @(negedge clk);
        vld[0] = 1'b1; a0 = 4'b1011; b0 = 4'b0110;
        @(posedge clk); #1;
        vld[0] = 1'b0; a0 = 4'b0000; b0 = 4'b1111;
        watch("basic", 0, 5, 16'h000B, 16'h0006, 16'h000F, 16'h0001, 16'h0008, 16'h0018, 16'h000F);

        // Back-to-back: (F,0) then (5,A) with in_valid held; valid dropped mid second frame.
        @(negedge clk);
        vld[0] = 1'b1; a0 = 4'hF; b0 = 4'h0;
        @(posedge clk); #1;
        a0 = 4'h5; b0 = 4'hA;
        fork
            watch("b2b", 0, 9, 16'h005F, 16'h00A0, 16'h00FF, 16'h0011, 16'h0088, 16'h0188, 16'h00FF);
            begin
                repeat (5) @(negedge clk);
                vld[0] = 1'b0;
            end
        join

        // MSB first: a=1000 b=0001.
        @(negedge clk);
        vld[1] = 1'b1; a1 = 4'b1000; b1 = 4'b0001;
        @(posedge clk); #1;
        vld[1] = 1'b0;
        watch("msb", 1, 5, 16'h0001, 16'h0008, 16'h000F, 16'h0001, 16'h0008, 16'h0018, 16'h000F);

        // Gap of 2 with in_valid held: no accept while busy, second pair taken from IDLE.
        @(negedge clk);
        vld[2] = 1'b1; a2 = 4'h3; b2 = 4'hC;
        @(posedge clk); #1;
        a2 = 4'h9; b2 = 4'h6;
        fork
            watch("gap", 2, 11, 16'h0483, 16'h030C, 16'h078F, 16'h0081, 16'h0408, 16'h0040, 16'h07BF);
            begin
                repeat (9) @(negedge clk);
                vld[2] = 1'b0;
            end
        join
        // Trailing gap of the second frame, then IDLE.
        watch("gap_tail", 2, 3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'h0003);

        // Reset during the second bit drops the frame.
        @(negedge clk);
        vld[0] = 1'b1; a0 = 4'hF; b0 = 4'hF;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid_bit0_bv", 32'(bv[0]), 32'h1);
        @(negedge clk);
        chk("rst_mid_bit1_sa", 32'(sa[0]), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        idle_check("rst_mid");

        // Reset wins over a simultaneous in_valid.
        vld[0] = 1'b1; a0 = 4'b0010; b0 = 4'b1101;
        @(negedge clk);
        idle_check("rst_vs_vld");
        reset = 1'b0;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        watch("post_rst", 0, 5, 16'h0002, 16'h000D, 16'h000F, 16'h0001, 16'h0008, 16'h0018, 16'h000F);

        @(negedge clk);
        idle_check("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
